alu_arbiter: RTL

//   Shares the single combinational alu between two requesters: port A (execute stage)
//   and port B (address/branch-compare helper).

---
 rtl/alu_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Shares one combinational alu between requester A (execute) and requester B (address/branch helper).
// Round-robin grant, one alu operation per cycle, and a registered one-entry response buffer per requester.
module alu_arbiter #(
  parameter int XLEN      = 32,
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_req_valid,
  output logic            a_req_ready,
  input  logic [3:0]      a_op,
  input  logic [XLEN-1:0] a_in1,
  input  logic [XLEN-1:0] a_in2,
  output logic            a_resp_valid,
  input  logic            a_resp_ready,
  output logic [XLEN-1:0] a_resp_data,
  input  logic            b_req_valid,
  output logic            b_req_ready,
  input  logic [3:0]      b_op,
  input  logic [XLEN-1:0] b_in1,
  input  logic [XLEN-1:0] b_in2,
  output logic            b_resp_valid,
  input  logic            b_resp_ready,
  output logic [XLEN-1:0] b_resp_data,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  input  logic [XLEN-1:0] alu_out
);

  // Handshake: a request transfers on a cycle where X_req_valid && X_req_ready;
  // a response transfers on a cycle where X_resp_valid && X_resp_ready.
  // X_req_ready is the grant and depends combinationally on X_resp_ready.

  logic prio;  // 0 = A holds priority, 1 = B holds priority
  logic a_elig, b_elig;
  logic grant_a, grant_b;

  // A requester is eligible when its buffer is empty or is being drained this cycle.
  assign a_elig = !rst && a_req_valid && (!a_resp_valid || a_resp_ready);
  assign b_elig = !rst && b_req_valid && (!b_resp_valid || b_resp_ready);

  assign grant_a = a_elig && (!b_elig || (prio == 1'b0));
  assign grant_b = b_elig && (!a_elig || (prio == 1'b1));

  assign a_req_ready = grant_a;
  assign b_req_ready = grant_b;

  always_comb begin
    alu_op  = 4'b0;
    alu_in1 = '0;
    alu_in2 = '0;
    if (grant_a) begin
      alu_op  = a_op;
      alu_in1 = a_in1;
      alu_in2 = a_in2;
    end else if (grant_b) begin
      alu_op  = b_op;
      alu_in1 = b_in1;
      alu_in2 = b_in2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_resp_valid <= 1'b0;
      a_resp_data  <= '0;
    end else if (grant_a) begin
      a_resp_valid <= 1'b1;
      a_resp_data  <= alu_out;
    end else if (a_resp_valid && a_resp_ready) begin
      a_resp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_resp_valid <= 1'b0;
      b_resp_data  <= '0;
    end else if (grant_b) begin
      b_resp_valid <= 1'b1;
      b_resp_data  <= alu_out;
    end else if (b_resp_valid && b_resp_ready) begin
      b_resp_valid <= 1'b0;
    end
  end

  // Priority passes to the requester that was not just served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= PRIO_INIT;
    end else if (grant_a) begin
      prio <= 1'b1;
    end else if (grant_b) begin
      prio <= 1'b0;
    end
  end

endmodule
